// File: rtl/a2g_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a2g_tx_pkg
//  Description : Shared types and constants for the a2g photon-packet TX
//                path: framing FSM states, status-word bit positions and
//                header field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package a2g_tx_pkg;

    // Framing FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } tx_state_e;

    // Status word layout
    localparam int STAT_AFULL    = 31;
    localparam int STAT_STICKY   = 30;
    localparam int STAT_FCNT_LSB = 16;
    localparam int STAT_FCNT_W   = 14;
    localparam int STAT_STALL_W  = 16;

    // Header word layout, MSB to LSB: frame count, pad, word count, timestamp
    localparam int HDR_FCNT_W   = 16;
    localparam int HDR_PAD_W    = 6;
    localparam int HDR_NWORDS_W = 10;
    localparam int HDR_TS_W     = 32;

    function automatic logic [HDR_FCNT_W+HDR_PAD_W+HDR_NWORDS_W+HDR_TS_W-1:0] hdr_pack(
        input logic [HDR_FCNT_W-1:0]   fcnt,
        input logic [HDR_NWORDS_W-1:0] nwords,
        input logic [HDR_TS_W-1:0]     ts
    );
        return {fcnt, {HDR_PAD_W{1'b0}}, nwords, ts};
    endfunction

endpackage
`default_nettype wire

// File: rtl/a2g_tx_status.sv
`default_nettype none
// ============================================================================
//  Module      : a2g_tx_status
//  Description : TX status word for the software-readable tx_full register:
//                registered afull, sticky stall flag, frame count and a
//                saturating stall-cycle counter. A clear pulse beats a
//                same-cycle set/increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module a2g_tx_status
    import a2g_tx_pkg::*;
(
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic                   tx_afull,
    input  logic                   ctrl_clr_status,
    input  logic                   stall,
    input  logic [STAT_FCNT_W-1:0] frame_cnt,
    output logic [31:0]            status_word
);
    localparam logic [STAT_STALL_W-1:0] c_stall_max = {STAT_STALL_W{1'b1}};
    localparam logic [STAT_STALL_W-1:0] c_stall_one = STAT_STALL_W'(1);

    logic                    afull_q,     afull_d;
    logic                    sticky_q,    sticky_d;
    logic [STAT_FCNT_W-1:0]  fcnt_q,      fcnt_d;
    logic [STAT_STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Next-state for status fields; clear has priority over set/increment
    always_comb begin
        afull_d     = tx_afull;
        fcnt_d      = frame_cnt;
        sticky_d    = sticky_q | stall;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != c_stall_max)) begin
            stall_cnt_d = stall_cnt_q + c_stall_one;
        end
        if (ctrl_clr_status) begin
            sticky_d    = 1'b0;
            stall_cnt_d = '0;
        end
    end

    // Status register bank
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            afull_q     <= 1'b0;
            sticky_q    <= 1'b0;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            afull_q     <= afull_d;
            sticky_q    <= sticky_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pack registered fields into the status word
    always_comb begin
        status_word                                    = '0;
        status_word[STAT_AFULL]                        = afull_q;
        status_word[STAT_STICKY]                       = sticky_q;
        status_word[STAT_FCNT_LSB +: STAT_FCNT_W]      = fcnt_q;
        status_word[0 +: STAT_STALL_W]                 = stall_cnt_q;
    end

endmodule
`default_nettype wire

// File: rtl/a2g_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : a2g_tx_ctrl
//  Description : Drains an FWFT event FIFO into the 10GbE TX interface as
//                framed packets. A frame starts on a full packet or on a
//                flush timeout, honours TX almost-full, and is followed by an
//                inter-frame gap. Outputs are combinational from state so
//                fifo_rd tracks tx_valid exactly during payload.
//                Build option A2G_TX_HDR_EN: when defined, each frame begins
//                with a header word {frame_cnt, pad, nwords, timestamp};
//                otherwise frames carry payload only and timestamp is unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module a2g_tx_ctrl
    import a2g_tx_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 10,
    parameter int PKT_WORDS   = 100,
    parameter int TIMEOUT_CYC = 1024,
    parameter int IFG_CYC     = 4
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              ctrl_en,
    input  logic              ctrl_clr_status,
    input  logic [31:0]       timestamp,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_rd,
    input  logic              tx_afull,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_end_of_frame,
    output logic [31:0]       status_word
);
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    localparam logic [CNT_W-1:0] c_pkt_lim = CNT_W'(PKT_WORDS);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [TMO_W-1:0] c_tmo_max = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] c_tmo_one = TMO_W'(1);
    localparam logic [GAP_W-1:0] c_gap_max = GAP_W'(IFG_CYC - 1);
    localparam logic [GAP_W-1:0] c_gap_one = GAP_W'(1);

    tx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] left_q,      left_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;

    logic             w_start;
    logic             w_stall;
    logic [CNT_W-1:0] w_nwords;

`ifdef A2G_TX_HDR_EN
    logic [CNT_W-1:0] nwords_q, nwords_d;
    logic [31:0]      ts_q,     ts_d;
`else
    logic             w_unused_hdr;
    assign w_unused_hdr = ^{timestamp, frame_cnt_q[15:14]};
`endif

    // Frame trigger: full packet, or a partial packet aged to the timeout
    assign w_start  = ctrl_en && !tx_afull &&
                      ((fifo_count >= c_pkt_lim) || (!fifo_empty && (tmo_cnt_q == c_tmo_max)));
    assign w_nwords = (fifo_count >= c_pkt_lim) ? c_pkt_lim : fifo_count;

    // Framing FSM next-state and combinational TX/FIFO strobes
    always_comb begin
        state_d         = state_q;
        left_d          = left_q;
        frame_cnt_d     = frame_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        gap_cnt_d       = gap_cnt_q;
`ifdef A2G_TX_HDR_EN
        nwords_d        = nwords_q;
        ts_d            = ts_q;
`endif
        tx_data         = '0;
        tx_valid        = 1'b0;
        tx_end_of_frame = 1'b0;
        fifo_rd         = 1'b0;
        w_stall         = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_empty) begin
                    tmo_cnt_d = '0;
                end else if ((fifo_count < c_pkt_lim) && (tmo_cnt_q != c_tmo_max)) begin
                    tmo_cnt_d = tmo_cnt_q + c_tmo_one;
                end
                if (w_start) begin
                    tmo_cnt_d = '0;
                    left_d    = w_nwords;
`ifdef A2G_TX_HDR_EN
                    nwords_d  = w_nwords;
                    ts_d      = timestamp;
                    state_d   = HEADER;
`else
                    state_d   = PAYLOAD;
`endif
                end
            end
`ifdef A2G_TX_HDR_EN
            HEADER: begin
                tx_data = DATA_W'(hdr_pack(frame_cnt_q, HDR_NWORDS_W'(nwords_q), ts_q));
                if (tx_afull) begin
                    w_stall = 1'b1;
                end else begin
                    tx_valid = 1'b1;
                    state_d  = PAYLOAD;
                end
            end
`endif
            PAYLOAD: begin
                tx_data = fifo_data;
                // An empty FIFO here is an underflow; treat it as a stall
                if (tx_afull || fifo_empty) begin
                    w_stall = 1'b1;
                end else begin
                    tx_valid = 1'b1;
                    fifo_rd  = 1'b1;
                    left_d   = left_q - c_cnt_one;
                    if (left_q == c_cnt_one) begin
                        tx_end_of_frame = 1'b1;
                        frame_cnt_d     = frame_cnt_q + 16'd1;
                        gap_cnt_d       = '0;
                        state_d         = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == c_gap_max) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_gap_one;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= IDLE;
            left_q      <= '0;
            frame_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
`ifdef A2G_TX_HDR_EN
            nwords_q    <= '0;
            ts_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef A2G_TX_HDR_EN
            nwords_q    <= nwords_d;
            ts_q        <= ts_d;
`endif
        end
    end

    a2g_tx_status u_status (
        .user_clk        (user_clk),
        .user_rst        (user_rst),
        .tx_afull        (tx_afull),
        .ctrl_clr_status (ctrl_clr_status),
        .stall           (w_stall),
        .frame_cnt       (frame_cnt_q[STAT_FCNT_W-1:0]),
        .status_word     (status_word)
    );

endmodule
`default_nettype wire

// File: tb/tb_a2g_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2g_tx_ctrl
//  Description : Randomised scoreboard bench for a2g_tx_ctrl. A queue-based
//                FWFT FIFO feeds the DUT; pushed words go to a scoreboard
//                queue and a negedge monitor checks every TX cycle and the
//                status word against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a2g_tx_ctrl;
    localparam int DATA_W      = 64;
    localparam int CNT_W       = 10;
    localparam int PKT_WORDS   = 100;
    localparam int TIMEOUT_CYC = 1024;
    localparam int IFG_CYC     = 4;
`ifdef A2G_TX_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int P_IDLE = 0, P_HDR = 1, P_PAY = 2, P_GAP = 3;

    logic              user_clk = 1'b0;
    logic              user_rst = 1'b1;
    logic              ctrl_en = 1'b0;
    logic              ctrl_clr_status = 1'b0;
    logic              tx_afull = 1'b0;
    logic [31:0]       timestamp = 32'h1234_0000;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty = 1'b1;
    logic [CNT_W-1:0]  fifo_count = '0;
    logic              fifo_rd, tx_valid, tx_end_of_frame;
    logic [DATA_W-1:0] tx_data;
    logic [31:0]       status_word;

    a2g_tx_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .PKT_WORDS(PKT_WORDS),
        .TIMEOUT_CYC(TIMEOUT_CYC), .IFG_CYC(IFG_CYC)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst), .ctrl_en(ctrl_en),
        .ctrl_clr_status(ctrl_clr_status), .timestamp(timestamp),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_rd(fifo_rd), .tx_afull(tx_afull), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame),
        .status_word(status_word)
    );

    always #5 user_clk = ~user_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model and scoreboard queues ----------------
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit pop_req = 1'b0;
    int cyc = 0;
    int seq = 0;

    always @(posedge user_clk) begin
        logic [DATA_W-1:0] dropped;
        cyc++;
        if (pop_req && fifo_q.size() > 0) dropped = fifo_q.pop_front();
        #2;
        timestamp  = timestamp + 32'd1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_count = CNT_W'(fifo_q.size());
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] w;
            w = {$urandom, 32'(seq)};
            seq++;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    // ---------------- Reference model / monitor ----------------
    int phase = P_IDLE, run = 0, fc = 0, nw = 0, left = 0, gap_left = 0, scnt = 0;
    bit sticky = 1'b0, init = 1'b0, first_pending = 1'b0;
    logic [31:0] ts_l = '0, exp_status = '0;
    int frame_words = 0, frames_done = 0, frames_started = 0, start_cyc = 0;

    always @(negedge user_clk) begin
        bit stall, eof_now, start;
        logic [DATA_W-1:0] w;
        pop_req = (fifo_rd === 1'b1);
        if (init) begin
            chk("status_word", status_word, exp_status);
            stall = 1'b0;
            eof_now = 1'b0;
            case (phase)
                P_IDLE: begin
                    chk("idle_strobes", {tx_valid, fifo_rd, tx_end_of_frame}, 3'b000);
                    start = ctrl_en && !tx_afull &&
                            (fifo_count >= PKT_WORDS || (!fifo_empty && run == TIMEOUT_CYC - 1));
                    if (fifo_empty) run = 0;
                    else if (fifo_count < PKT_WORDS && run < TIMEOUT_CYC - 1) run++;
                    if (start) begin
                        nw = (fifo_count >= PKT_WORDS) ? PKT_WORDS : int'(fifo_count);
                        left = nw;
                        ts_l = timestamp;
                        phase = HDR ? P_HDR : P_PAY;
                        frames_started++;
                        frame_words = 0;
                        first_pending = 1'b1;
                    end
                end
                P_HDR: begin
                    if (tx_afull) begin
                        chk("hdr_stall_strobes", {tx_valid, fifo_rd, tx_end_of_frame}, 3'b000);
                        stall = 1'b1;
                    end else begin
                        chk("hdr_strobes", {tx_valid, fifo_rd, tx_end_of_frame}, 3'b100);
                        chk("hdr_data", tx_data, {16'(fc), 6'b0, 10'(nw), ts_l});
                        if (first_pending) begin start_cyc = cyc; first_pending = 1'b0; end
                        phase = P_PAY;
                    end
                end
                P_PAY: begin
                    if (tx_afull || fifo_empty) begin
                        chk("pay_stall_strobes", {tx_valid, fifo_rd, tx_end_of_frame}, 3'b000);
                        stall = 1'b1;
                    end else begin
                        chk("pay_strobes", {tx_valid, fifo_rd}, 2'b11);
                        chk("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
                        w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                        chk("pay_data", tx_data, w);
                        chk("pay_eof", tx_end_of_frame, left == 1);
                        if (first_pending) begin start_cyc = cyc; first_pending = 1'b0; end
                        frame_words++;
                        left--;
                        if (left == 0) begin
                            phase = P_GAP;
                            gap_left = IFG_CYC;
                            eof_now = 1'b1;
                            frames_done++;
                        end
                    end
                end
                default: begin
                    chk("gap_strobes", {tx_valid, fifo_rd, tx_end_of_frame}, 3'b000);
                    gap_left--;
                    if (gap_left == 0) phase = P_IDLE;
                end
            endcase
            if (phase != P_IDLE) run = 0;
            if (ctrl_clr_status) begin
                sticky = 1'b0;
                scnt = 0;
            end else if (stall) begin
                sticky = 1'b1;
                if (scnt < 65535) scnt++;
            end
            exp_status = {tx_afull, sticky, 14'(fc), 16'(scnt)};
            if (eof_now) fc = (fc + 1) % 65536;
        end
        if (user_rst === 1'b1) begin
            init = 1'b1;
            phase = P_IDLE; run = 0; fc = 0; left = 0; gap_left = 0;
            sticky = 1'b0; scnt = 0; exp_status = '0;
            first_pending = 1'b0; frame_words = 0;
        end
    end

    // ---------------- Bounded waits ----------------
    task automatic wait_idle_empty(input string what, input int budget);
        int k = 0;
        while (!(phase == P_IDLE && fifo_q.size() == 0) && k < budget) begin tick(1); k++; end
        chk(what, (phase == P_IDLE && fifo_q.size() == 0), 1'b1);
    endtask

    task automatic wait_done(input string what, input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin tick(1); k++; end
        chk(what, frames_done >= target, 1'b1);
    endtask

    task automatic wait_words(input string what, input int started, input int words, input int budget);
        int k = 0;
        while (!(frames_started >= started && frame_words >= words && phase == P_PAY) && k < budget) begin
            tick(1); k++;
        end
        chk(what, (frames_started >= started && frame_words >= words), 1'b1);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int p, fs;
        tick(3);
        user_rst = 1'b0;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_fifo_rd", fifo_rd, 1'b0);
        chk("rst_status", status_word, 32'h0);
        tick(2);

        // Full packet of 100 words
        ctrl_en = 1'b1;
        push_words(PKT_WORDS);
        wait_done("full_frame_done", 1, 400);
        tick(2);
        chk("fcnt_after_first", status_word[29:16], 14'd1);
        wait_idle_empty("idle_after_first", 100);
        tick(5);

        // Partial packet flushed by timeout
        push_words(7);
        p = cyc;
        wait_done("tmo_frame_done", 2, 1400);
        chk("tmo_latency", start_cyc - p, TIMEOUT_CYC);
        wait_idle_empty("idle_after_tmo", 100);

        // Backpressure mid-payload, then status clearing
        ctrl_clr_status = 1'b1; tick(1); ctrl_clr_status = 1'b0;
        fs = frames_started;
        push_words(PKT_WORDS);
        wait_words("reach_word30", fs + 1, 30, 400);
        tx_afull = 1'b1; tick(10); tx_afull = 1'b0;
        tick(2);
        chk("stall_count", status_word[15:0], 16'd10);
        chk("stall_sticky", status_word[30], 1'b1);
        ctrl_clr_status = 1'b1; tick(1); ctrl_clr_status = 1'b0;
        tick(1);
        chk("clr_count", status_word[15:0], 16'd0);
        chk("clr_sticky", status_word[30], 1'b0);
        tx_afull = 1'b1; ctrl_clr_status = 1'b1; tick(1);
        tx_afull = 1'b0; ctrl_clr_status = 1'b0; tick(1);
        chk("clr_vs_stall_count", status_word[15:0], 16'd0);
        wait_idle_empty("idle_after_stall", 400);

        // ctrl_en dropped mid-frame
        fs = frames_started;
        push_words(350);
        wait_words("reach_word50", fs + 1, 50, 400);
        ctrl_en = 1'b0;
        wait_done("en_drop_frame_done", frames_done + 1, 200);
        tick(300);
        chk("no_restart", frames_started, fs + 1);
        chk("words_queued", fifo_q.size(), 250);
        ctrl_en = 1'b1;
        wait_idle_empty("idle_after_drain", 3000);

        // Reset mid-payload
        fs = frames_started;
        push_words(PKT_WORDS);
        wait_words("reach_word20", fs + 1, 20, 400);
        user_rst = 1'b1; tick(1);
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_eof", tx_end_of_frame, 1'b0);
        chk("midrst_fifo_rd", fifo_rd, 1'b0);
        chk("midrst_tx_data", tx_data, 64'h0);
        chk("midrst_status", status_word, 32'h0);
        user_rst = 1'b0;
        wait_idle_empty("idle_after_rst", 2000);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if (fifo_q.size() < 800 && $urandom_range(0, 5) == 0) push_words($urandom_range(1, 8));
            tx_afull = ($urandom_range(0, 9) == 0);
            ctrl_clr_status = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) ctrl_en = ~ctrl_en;
            tick(1);
        end
        ctrl_en = 1'b1; tx_afull = 1'b0; ctrl_clr_status = 1'b0;
        wait_idle_empty("idle_after_random", 20000);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
